// File: rtl/mem_wb_stage_pkg.sv
// mem_wb_stage_pkg: write-back select and load funct3 encodings shared by decode, regfile and write-back
package mem_wb_stage_pkg;
  typedef enum logic [1:0] {WB_DMEM = 2'd0, WB_ALU = 2'd1, WB_PC4 = 2'd2} wb_sel_e;
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } ld_f3_e;
endpackage

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: memory-stage instruction fields handed to write-back
interface mem_wb_stage_if #(parameter int XLEN = 32);
  logic            m_valid;
  logic [4:0]      m_rd;
  logic            m_reg_we;
  logic [1:0]      m_WBSel;
  logic [XLEN-1:0] m_PC;
  logic [XLEN-1:0] m_ALU_out;
  logic [2:0]      m_funct3;
  modport master(output m_valid, m_rd, m_reg_we, m_WBSel, m_PC, m_ALU_out, m_funct3);
  modport slave(input m_valid, m_rd, m_reg_we, m_WBSel, m_PC, m_ALU_out, m_funct3);
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// load_align: extracts and extends the addressed byte/half of a load word
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = word[{offset, 3'b000} +: 8];
    h = word[{offset[1], 4'b0000} +: 16];
    data = (funct3 == F3_LB)  ? {{(XLEN-8){b[7]}}, b} :
           (funct3 == F3_LBU) ? {{(XLEN-8){1'b0}}, b} :
           (funct3 == F3_LH)  ? {{(XLEN-16){h[15]}}, h} :
           (funct3 == F3_LHU) ? {{(XLEN-16){1'b0}}, h} : word;
  end
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register with load alignment, stall data hold and retire counter
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  mem_wb_stage_if.slave    m,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             write_enable,
  output logic [4:0]       rd,
  output logic [1:0]       WBSel,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  ALU_out,
  output logic [XLEN-1:0]  dmem_out,
  output logic [CNT_W-1:0] instret
);
  logic             valid_q, valid_d, reg_we_q, reg_we_d, hold_valid_q, hold_valid_d;
  logic [4:0]       rd_q, rd_d;
  logic [1:0]       wbsel_q, wbsel_d;
  logic [2:0]       f3_q, f3_d;
  logic [XLEN-1:0]  pc_q, pc_d, alu_q, alu_d, hold_q, hold_d, aligned;
  logic [CNT_W-1:0] instret_q, instret_d;
  always_comb begin
    valid_d      = stall ? valid_q  : m.m_valid && !flush;
    reg_we_d     = stall ? reg_we_q : m.m_reg_we;
    rd_d         = stall ? rd_q     : m.m_rd;
    wbsel_d      = stall ? wbsel_q  : m.m_WBSel;
    pc_d         = stall ? pc_q     : m.m_PC;
    alu_d        = stall ? alu_q    : m.m_ALU_out;
    f3_d         = stall ? f3_q     : m.m_funct3;
    // dmem_rdata is only valid in the first occupancy cycle, so latch it once a stall begins
    hold_valid_d = stall;
    hold_d       = (stall && !hold_valid_q) ? dmem_rdata : hold_q;
    instret_d    = instret_q + CNT_W'(valid_q && !stall);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      reg_we_q     <= 1'b0;
      rd_q         <= '0;
      wbsel_q      <= '0;
      pc_q         <= '0;
      alu_q        <= '0;
      f3_q         <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      instret_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_we_q     <= reg_we_d;
      rd_q         <= rd_d;
      wbsel_q      <= wbsel_d;
      pc_q         <= pc_d;
      alu_q        <= alu_d;
      f3_q         <= f3_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      instret_q    <= instret_d;
    end
  end
  load_align #(.XLEN(XLEN)) u_align (
    .word  (hold_valid_q ? hold_q : dmem_rdata),
    .funct3(f3_q),
    .offset(alu_q[1:0]),
    .data  (aligned)
  );
  // empty slots show zero load data so outputs stay deterministic
  assign dmem_out     = valid_q ? aligned : '0;
  assign write_enable = valid_q && reg_we_q && (rd_q != 5'd0) && !stall;
  assign rd           = rd_q;
  assign WBSel        = wbsel_q;
  assign PC           = pc_q;
  assign ALU_out      = alu_q;
  assign instret      = instret_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: directed tests for mem_wb_stage, plus a 4-bit counter instance for wrap
module tb_mem_wb_stage;
  import mem_wb_stage_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        we, we4;
  logic [4:0]  rd, rd4;
  logic [1:0]  wbsel, wbsel4;
  logic [31:0] pc, alu, dout, pc4, alu4, dout4;
  logic [63:0] instret, exp_cnt = '0;
  logic [3:0]  instret4;
  logic        wb_v = 1'b0;
  int          checks = 0, errors = 0;
  mem_wb_stage_if #(.XLEN(32)) bus ();
  mem_wb_stage dut (
    .clk(clk), .rst(rst), .m(bus), .stall(stall), .flush(flush), .dmem_rdata(dmem_rdata),
    .write_enable(we), .rd(rd), .WBSel(wbsel), .PC(pc), .ALU_out(alu), .dmem_out(dout), .instret(instret)
  );
  mem_wb_stage #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .m(bus), .stall(stall), .flush(flush), .dmem_rdata(dmem_rdata),
    .write_enable(we4), .rd(rd4), .WBSel(wbsel4), .PC(pc4), .ALU_out(alu4), .dmem_out(dout4), .instret(instret4)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic [4:0] r, input logic w, input logic [1:0] ws,
                       input logic [31:0] p, input logic [31:0] a, input logic [2:0] f3);
    bus.m_valid = v; bus.m_rd = r; bus.m_reg_we = w; bus.m_WBSel = ws;
    bus.m_PC = p; bus.m_ALU_out = a; bus.m_funct3 = f3;
  endtask
  // expected retire count follows the inputs applied at each edge
  task automatic tick();
    if (rst) begin
      wb_v = 1'b0; exp_cnt = '0;
    end else if (!stall) begin
      if (wb_v) exp_cnt = exp_cnt + 64'd1;
      wb_v = bus.m_valid && !flush;
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset();
    drive(1'b1, 5'd7, 1'b1, 2'd2, 32'h44, 32'h1233, 3'b000);
    rst = 1'b1; stall = 1'b1; flush = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    tick(); tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", we); end
    checks++; if (rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d exp 0", rd); end
    checks++; if (wbsel !== 2'd0) begin errors++; $display("FAIL reset_wbsel: got %0d exp 0", wbsel); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc); end
    checks++; if (alu !== 32'h0) begin errors++; $display("FAIL reset_alu: got %h exp 0", alu); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout: got %h exp 0", dout); end
    checks++; if (instret !== 64'h0) begin errors++; $display("FAIL reset_instret: got %0d exp 0", instret); end
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    tick();
  endtask
  task automatic test_lb();
    drive(1'b1, 5'd3, 1'b1, WB_DMEM, 32'h100, 32'h1003, F3_LB);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    dmem_rdata = 32'h80FF_1234; #1;
    checks++; if (dout !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_dout: got %h exp ffffff80", dout); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL lb_we: got %b exp 1", we); end
    checks++; if (rd !== 5'd3) begin errors++; $display("FAIL lb_rd: got %0d exp 3", rd); end
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL lb_pc: got %h exp 100", pc); end
    checks++; if (alu !== 32'h1003) begin errors++; $display("FAIL lb_alu: got %h exp 1003", alu); end
    tick();
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL lb_instret: got %0d exp %0d", instret, exp_cnt); end
    checks++; if (instret !== 64'd1) begin errors++; $display("FAIL lb_instret_abs: got %0d exp 1", instret); end
  endtask
  task automatic test_align();
    logic [2:0]  f3 [8] = '{3'b000, 3'b100, 3'b000, 3'b001, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [31:0] ad [8] = '{32'h1003, 32'h1003, 32'h1000, 32'h1001, 32'h1002, 32'h1002, 32'h1003, 32'h1000};
    logic [31:0] wd [8] = '{32'h80FF1234, 32'h80FF1234, 32'h80FF1234, 32'h80FF1234,
                            32'h80FF1234, 32'hBEEF0001, 32'hCAFEF00D, 32'h12345678};
    logic [31:0] ex [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00000034, 32'h00001234,
                            32'hFFFF80FF, 32'h0000BEEF, 32'hCAFEF00D, 32'h12345678};
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 5'(i + 1), 1'b1, WB_DMEM, 32'h200 + 32'(i * 4), ad[i], f3[i]);
      tick();
      dmem_rdata = wd[i]; #1;
      checks++; if (dout !== ex[i]) begin errors++; $display("FAIL align_%0d: got %h exp %h", i, dout, ex[i]); end
      checks++; if (we !== 1'b1) begin errors++; $display("FAIL align_we_%0d: got %b exp 1", i, we); end
    end
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    tick();
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL align_instret: got %0d exp %0d", instret, exp_cnt); end
  endtask
  task automatic test_hold();
    logic [63:0] c0;
    drive(1'b1, 5'd7, 1'b1, WB_DMEM, 32'h300, 32'h2000, F3_LW);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    c0 = instret;
    dmem_rdata = 32'hCAFE_F00D; stall = 1'b1; #1;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL hold_we_0: got %b exp 0", we); end
    for (int i = 1; i < 3; i++) begin
      tick();
      dmem_rdata = 32'h0; #1;
      checks++; if (dout !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_dout_%0d: got %h exp cafef00d", i, dout); end
      checks++; if (we !== 1'b0) begin errors++; $display("FAIL hold_we_%0d: got %b exp 0", i, we); end
      checks++; if (instret !== c0) begin errors++; $display("FAIL hold_instret_%0d: got %0d exp %0d", i, instret, c0); end
    end
    tick();
    stall = 1'b0; #1;
    checks++; if (dout !== 32'hCAFE_F00D) begin errors++; $display("FAIL hold_release_dout: got %h exp cafef00d", dout); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL hold_release_we: got %b exp 1", we); end
    tick(); tick();
    checks++; if (instret !== c0 + 64'd1) begin errors++; $display("FAIL hold_instret: got %0d exp %0d", instret, c0 + 64'd1); end
    checks++; if (dut.hold_valid_q !== 1'b0) begin errors++; $display("FAIL hold_clear: got %b exp 0", dut.hold_valid_q); end
  endtask
  task automatic test_flush();
    logic [63:0] c0;
    drive(1'b1, 5'd9, 1'b1, WB_ALU, 32'h400, 32'h55, F3_LW);
    tick();
    drive(1'b1, 5'd5, 1'b1, WB_ALU, 32'h404, 32'h66, F3_LW);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    c0 = instret;
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL flush_we: got %b exp 0", we); end
    tick();
    checks++; if (instret !== c0) begin errors++; $display("FAIL flush_instret: got %0d exp %0d", instret, c0); end
    drive(1'b1, 5'd10, 1'b1, WB_ALU, 32'h408, 32'h77, F3_LW);
    tick();
    drive(1'b1, 5'd5, 1'b1, WB_ALU, 32'h40C, 32'h88, F3_LW);
    stall = 1'b1; flush = 1'b1;
    tick();
    stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000); #1;
    checks++; if (rd !== 5'd10) begin errors++; $display("FAIL stallflush_rd: got %0d exp 10", rd); end
    checks++; if (alu !== 32'h77) begin errors++; $display("FAIL stallflush_alu: got %h exp 77", alu); end
    checks++; if (we !== 1'b1) begin errors++; $display("FAIL stallflush_we: got %b exp 1", we); end
    c0 = instret;
    tick();
    checks++; if (instret !== c0 + 64'd1) begin errors++; $display("FAIL stallflush_instret: got %0d exp %0d", instret, c0 + 64'd1); end
  endtask
  task automatic test_rd0();
    logic [63:0] c0;
    c0 = instret;
    drive(1'b1, 5'd0, 1'b1, WB_ALU, 32'h500, 32'h99, F3_LW);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rd0_we: got %b exp 0", we); end
    tick();
    checks++; if (instret !== c0 + 64'd1) begin errors++; $display("FAIL rd0_instret: got %0d exp %0d", instret, c0 + 64'd1); end
  endtask
  task automatic test_wrap();
    int n = 0;
    drive(1'b1, 5'd1, 1'b1, WB_ALU, 32'h600, 32'h1, F3_LW);
    while (exp_cnt[3:0] != 4'd15 && n < 40) begin tick(); n++; end
    checks++; if (instret4 !== 4'd15) begin errors++; $display("FAIL wrap_pre: got %0d exp 15", instret4); end
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    tick();
    checks++; if (instret4 !== 4'd0) begin errors++; $display("FAIL wrap_post: got %0d exp 0", instret4); end
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL wrap_wide: got %0d exp %0d", instret, exp_cnt); end
  endtask
  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd4, 1'b1, WB_DMEM, 32'h700, 32'h3000, F3_LW);
    tick();
    drive(1'b0, 5'd0, 1'b0, 2'd0, 32'h0, 32'h0, 3'b000);
    dmem_rdata = 32'h1111_2222; stall = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL rststall_we: got %b exp 0", we); end
    checks++; if (dut.hold_valid_q !== 1'b0) begin errors++; $display("FAIL rststall_hold: got %b exp 0", dut.hold_valid_q); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL rststall_instret: got %0d exp 0", instret); end
    checks++; if (instret4 !== 4'd0) begin errors++; $display("FAIL rststall_instret4: got %0d exp 0", instret4); end
    checks++; if (dout !== 32'h0) begin errors++; $display("FAIL rststall_dout: got %h exp 0", dout); end
    rst = 1'b0; stall = 1'b0;
    tick();
  endtask
  initial begin
    test_reset();
    test_lb();
    test_align();
    test_hold();
    test_flush();
    test_rd0();
    test_wrap();
    test_reset_mid_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width.
REQ-002 SHALL have parameter CNT_W, default 64, meaning retired-instruction counter width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port m_valid  input  1  memory stage holds a real instruction.
REQ-006 SHALL have port m_rd  input  5  destination register.
REQ-007 SHALL have port m_reg_we  input  1  instruction writes rd.
REQ-008 SHALL have port m_WBSel  input  2  write-back source: 0 dmem, 1 ALU, 2 PC+4.
REQ-009 SHALL have port m_PC  input  XLEN  instruction PC, not incremented.
REQ-010 SHALL have port m_ALU_out  input  XLEN  ALU result; for loads also the byte address.
REQ-011 SHALL have port m_funct3  input  3  load type.
REQ-012 SHALL have port stall  input  1  hold write-back contents.
REQ-013 SHALL have port flush  input  1  kill the instruction entering write-back.
REQ-014 SHALL have port dmem_rdata  input  XLEN  synchronous-read word; valid only in the first cycle of write-back occupancy.
REQ-015 SHALL have ports write_enable 1, rd 5, WBSel 2, PC XLEN, ALU_out XLEN, dmem_out XLEN  outputs  drive the register file directly.
REQ-016 SHALL have port instret  output  CNT_W  retired-instruction count.

Function
REQ-017 SHALL, on a clk edge with !rst && !stall, capture all m_* fields and set wb_valid to m_valid && !flush.
REQ-018 SHALL, with stall=1, keep all stage registers unchanged. flush is ignored in that cycle, so stall wins.
REQ-019 SHALL drive write_enable = wb_valid && wb_reg_we && (rd != 0) && !stall, combinationally from stage registers.
REQ-020 SHALL pass rd, WBSel, PC and ALU_out straight from stage registers with zero added latency; PC is not incremented here.
REQ-021 SHALL align load data from the offset ALU_out[1:0]:
- funct3 000 LB: byte at offset*8, sign-extended.
- 100 LBU: same byte, zero-extended.
- 001 LH: half at offset[1]*16, sign-extended.
- 101 LHU: same half, zero-extended.
- 010 LW and all other codes: full word.
REQ-022 SHALL ignore offset[0] for halfword loads and the whole offset for word loads; misaligned access is not trapped.
REQ-023 SHALL, in the first stalled cycle of an occupancy, capture dmem_rdata into a hold register and set hold_valid.
REQ-024 SHALL align from the hold register while hold_valid=1, and from dmem_rdata otherwise.
REQ-025 SHALL clear hold_valid whenever the stage advances (stall=0).
REQ-026 SHALL increment instret by 1 on each edge where wb_valid && !stall, wrapping modulo 2^CNT_W; non-writing instructions (stores, branches) also count.
REQ-027 SHALL present a flushed or invalid slot as write_enable=0; the other outputs are don't-care but must stay deterministic.

Reset
REQ-028 SHALL, on rst=1 at a clk edge, clear wb_valid, hold_valid, all stage registers and instret to 0, overriding stall and flush.
REQ-029 SHALL hold every output at 0 in the cycle after reset, including write_enable, dmem_out and instret.

Structure
REQ-030 SHALL take the WBSel encodings (WB_DMEM=0, WB_ALU=1, WB_PC4=2) and the load funct3 codes from a shared package, also used by decode and the register file.
REQ-031 SHALL implement alignment in one combinational sub-module, load_align (inputs: word, funct3, offset; output: aligned data).

Verification
REQ-032 SHALL verify LB sign extension: LB, ALU_out=0x1003, dmem_rdata=0x80FF1234 -> dmem_out=0xFFFFFF80, write_enable=1 one cycle after capture.
REQ-033 SHALL verify LHU: LHU, offset 2, dmem_rdata=0xBEEF0001 -> dmem_out=0x0000BEEF.
REQ-034 SHALL verify hold under stall: LW, word 0xCAFEF00D; stall for 3 cycles while dmem_rdata changes to 0x0 -> dmem_out stays 0xCAFEF00D and write_enable stays 0 until stall drops; instret +1 exactly once.
REQ-035 SHALL verify flush and stall priority:
- flush=1 with m_valid=1, rd=5 -> no write, instret unchanged.
- flush=1 together with stall=1 -> the prior instruction is preserved.
REQ-036 SHALL verify the rd=0 and counter-wrap boundaries:
- ALU op with rd=0 -> write_enable=0, instret increments.
- Counter preset near max with CNT_W=4: 15 -> 0 on the next retire.
REQ-037 SHALL verify reset mid-stall: rst during a held load -> the next cycle shows write_enable=0, hold_valid=0, instret=0.
